// File: rtl/and_bitwise.sv
`default_nettype none
// ============================================================================
// Module   : and_bitwise
// Brief    : Registered 4-bit bitwise AND with valid, zero/ones flags and
//            population count, all updated together on capture.
// Revision : 1.0 - initial release
// ============================================================================
module and_bitwise #(
    parameter logic [3:0] RST_VAL = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x0,
    input  logic       x1,
    input  logic       x2,
    input  logic       x3,
    input  logic       y0,
    input  logic       y1,
    input  logic       y2,
    input  logic       y3,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    input  logic       in_valid,
    output logic       out_valid,
    output logic       all_zero,
    output logic       all_ones,
    output logic [2:0] pop_cnt
);

    // Reset flag values are derived from RST_VAL so they match the reset result.
    localparam logic [2:0] c_RST_POP  = {2'b00, RST_VAL[0]} + {2'b00, RST_VAL[1]}
                                      + {2'b00, RST_VAL[2]} + {2'b00, RST_VAL[3]};
    localparam logic       c_RST_ZERO = (RST_VAL == 4'b0000);
    localparam logic       c_RST_ONES = (RST_VAL == 4'b1111);

    logic [3:0] w_and;
    logic [2:0] w_pop;
    logic       w_zero;
    logic       w_ones;

    logic [3:0] r_result;
    logic       r_out_valid;
    logic       r_all_zero;
    logic       r_all_ones;
    logic [2:0] r_pop_cnt;

    // Each result bit depends only on its own operand pair.
    assign w_and[0] = x0 & y0;
    assign w_and[1] = x1 & y1;
    assign w_and[2] = x2 & y2;
    assign w_and[3] = x3 & y3;

    assign w_pop  = {2'b00, w_and[0]} + {2'b00, w_and[1]}
                  + {2'b00, w_and[2]} + {2'b00, w_and[3]};
    assign w_zero = (w_and == 4'b0000);
    assign w_ones = (w_and == 4'b1111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= RST_VAL;
            r_out_valid <= 1'b0;
            r_all_zero  <= c_RST_ZERO;
            r_all_ones  <= c_RST_ONES;
            r_pop_cnt   <= c_RST_POP;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result   <= w_and;
                r_all_zero <= w_zero;
                r_all_ones <= w_ones;
                r_pop_cnt  <= w_pop;
            end
        end
    end

    assign o0        = r_result[0];
    assign o1        = r_result[1];
    assign o2        = r_result[2];
    assign o3        = r_result[3];
    assign out_valid = r_out_valid;
    assign all_zero  = r_all_zero;
    assign all_ones  = r_all_ones;
    assign pop_cnt   = r_pop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_and_bitwise.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_bitwise
// Brief    : Self-checking bench for and_bitwise against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_bitwise;

    localparam logic [3:0] c_RST_VAL = 4'b0000;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] ax;
    logic [3:0] by;
    logic       o0, o1, o2, o3;
    logic       out_valid, all_zero, all_ones;
    logic [2:0] pop_cnt;

    int checks;
    int errors;

    // Reference model state: the last accepted result and whether the
    // previous edge accepted a capture.
    logic [3:0] m_o;
    logic       m_v;

    and_bitwise #(.RST_VAL(c_RST_VAL)) dut (
        .clk(clk), .rst(rst),
        .x0(ax[0]), .x1(ax[1]), .x2(ax[2]), .x3(ax[3]),
        .y0(by[0]), .y1(by[1]), .y2(by[2]), .y3(by[3]),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .in_valid(in_valid), .out_valid(out_valid),
        .all_zero(all_zero), .all_ones(all_ones), .pop_cnt(pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {o3..o0, out_valid, all_zero, all_ones, pop_cnt}.
    function automatic logic [9:0] expect_vec(input logic [3:0] o, input logic v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (o[i]) n++;
        return {o, v, (o == 4'd0), (o == 4'd15), 3'(n)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {o3, o2, o1, o0, out_valid, all_zero, all_ones, pop_cnt};
    endfunction

    // Advance one clock, update the model, and leave time at edge+1.
    task automatic tick();
        logic cap;
        logic [3:0] res;
        cap = in_valid && !rst;
        res = ax & by;
        @(posedge clk);
        #1;
        if (rst) begin
            m_o = c_RST_VAL;
            m_v = 1'b0;
        end else begin
            if (cap) m_o = res;
            m_v = cap;
        end
    endtask

    task automatic test_reset();
        logic [9:0] e;
        rst = 1'b1; in_valid = 1'b0; ax = 4'h0; by = 4'h0;
        m_o = c_RST_VAL; m_v = 1'b0;
        #3;
        e = expect_vec(c_RST_VAL, 1'b0);
        checks++;
        if (dut_vec() !== e) begin
            errors++; $display("FAIL reset_state: got %b expected %b", dut_vec(), e);
        end
        // Edge coincident with reset must be ignored even with valid operands.
        in_valid = 1'b1; ax = 4'hF; by = 4'hF;
        tick();
        checks++;
        if (dut_vec() !== e) begin
            errors++; $display("FAIL reset_edge_ignored: got %b expected %b", dut_vec(), e);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tick();
        checks++;
        if (dut_vec() !== expect_vec(m_o, m_v)) begin
            errors++; $display("FAIL reset_release_idle: got %b expected %b", dut_vec(), expect_vec(m_o, m_v));
        end
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < 256; i++) begin
            ax = 4'(i >> 4); by = 4'(i); in_valid = 1'b1;
            tick();
            checks++;
            if (dut_vec() !== expect_vec(m_o, m_v)) begin
                errors++;
                $display("FAIL exhaustive x=%b y=%b: got %b expected %b", ax, by, dut_vec(), expect_vec(m_o, m_v));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL exhaustive_valid_drop: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flags();
        ax = 4'b1111; by = 4'b1111; in_valid = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== {4'b1111, 1'b1, 1'b0, 1'b1, 3'd4}) begin
            errors++; $display("FAIL flags_all_ones: got %b expected %b", dut_vec(), {4'b1111, 3'b101, 3'd4});
        end
        ax = 4'b1010; by = 4'b0101;
        tick();
        checks++;
        if (dut_vec() !== {4'b0000, 1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++; $display("FAIL flags_all_zero: got %b expected %b", dut_vec(), {4'b0000, 3'b110, 3'd0});
        end
        ax = 4'b1011; by = 4'b0110;
        tick();
        checks++;
        if (dut_vec() !== {4'b0010, 1'b1, 1'b0, 1'b0, 3'd1}) begin
            errors++; $display("FAIL flags_one_bit: got %b expected %b", dut_vec(), {4'b0010, 3'b100, 3'd1});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        ax = 4'b1100; by = 4'b1110; in_valid = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== {4'b1100, 1'b1, 1'b0, 1'b0, 3'd2}) begin
            errors++; $display("FAIL hold_capture: got %b expected %b", dut_vec(), {4'b1100, 3'b100, 3'd2});
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ax = 4'($urandom); by = 4'($urandom);
            tick();
            checks++;
            if (dut_vec() !== {4'b1100, 1'b0, 1'b0, 1'b0, 3'd2}) begin
                errors++; $display("FAIL hold_cycle%0d: got %b expected %b", k, dut_vec(), {4'b1100, 3'b000, 3'd2});
            end
        end
    endtask

    task automatic test_reset_midstream();
        ax = 4'hF; by = 4'hF; in_valid = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== expect_vec(4'hF, 1'b1)) begin
            errors++; $display("FAIL midrst_before: got %b expected %b", dut_vec(), expect_vec(4'hF, 1'b1));
        end
        #2;
        rst = 1'b1;
        #1;
        m_o = c_RST_VAL; m_v = 1'b0;
        checks++;
        if (dut_vec() !== expect_vec(c_RST_VAL, 1'b0)) begin
            errors++; $display("FAIL midrst_immediate: got %b expected %b", dut_vec(), expect_vec(c_RST_VAL, 1'b0));
        end
    endtask

    task automatic test_post_reset();
        // Release with valid operands already present; first edge captures.
        @(negedge clk);
        ax = 4'b0111; by = 4'b0101; in_valid = 1'b1;
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== {4'b0101, 1'b1, 1'b0, 1'b0, 3'd2}) begin
            errors++; $display("FAIL post_reset_capture: got %b expected %b", dut_vec(), {4'b0101, 3'b100, 3'd2});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            ax = 4'($urandom); by = 4'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (dut_vec() !== expect_vec(m_o, m_v)) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %b expected %b", k, dut_vec(), expect_vec(m_o, m_v));
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exhaustive();
        test_flags();
        test_hold();
        test_reset_midstream();
        test_post_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/and_bitwise.md
AND_BITWISE -- requirements
Module: and_bitwise

Interface
REQ-001 Parameter RST_VAL, default 4'b0000: value loaded into {o3,o2,o1,o0} on reset.
REQ-002 Ports, in this positional order: clk, rst, x0, x1, x2, x3, y0, y1, y2, y3, o0, o1, o2, o3, in_valid, out_valid, all_zero, all_ones, pop_cnt.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 x0..x3  input  1 each  operand A, bit 0 (x0) to bit 3 (x3).
REQ-007 y0..y3  input  1 each  operand B, bit 0 (y0) to bit 3 (y3).
REQ-008 in_valid  input  1  operands valid; capture enable.
REQ-009 o0..o3  output  1 each  registered result, o_i = x_i AND y_i.
REQ-010 out_valid  output  1  result registers updated on the previous edge.
REQ-011 all_zero  output  1  registered flag: result == 4'b0000.
REQ-012 all_ones  output  1  registered flag: result == 4'b1111.
REQ-013 pop_cnt  output  3  registered count of ones in the result, range 0..4.

Function
REQ-014 On a rising clk with rst=0 and in_valid=1, the block SHALL load o_i <= x_i & y_i for i=0..3, each bit independently; there is no cross-bit interaction.
REQ-015 Latency SHALL be exactly one clock: operands sampled at edge N appear on o0..o3 after edge N.
REQ-016 On a rising clk with in_valid=0, o0..o3, all_zero, all_ones and pop_cnt SHALL hold their values.
REQ-017 out_valid SHALL be registered in_valid: it is 1 for exactly the cycle after each accepted capture and 0 otherwise.
REQ-018 all_zero, all_ones and pop_cnt SHALL be computed from the same operands and registered on the same edge as o0..o3, so they are always consistent with the visible result.
REQ-019 all_zero and all_ones SHALL never both be 1; pop_cnt SHALL equal o0+o1+o2+o3 at all times, including after reset.
REQ-020 Back-to-back captures (in_valid=1 on consecutive edges) SHALL be supported at full rate, with no bubbles and no handshake back-pressure.
REQ-021 X or Z on an operand bit SHALL not affect any other result bit.
REQ-022 The design SHALL have no internal state beyond the output registers.

Reset
REQ-023 While rst=1, outputs SHALL immediately (without a clock edge) take these values:
  - {o3..o0} = RST_VAL
  - out_valid = 0
  - all_zero, all_ones and pop_cnt consistent with RST_VAL (defaults: all_zero=1, all_ones=0, pop_cnt=0).
REQ-024 Reset asserted mid-stream SHALL discard any in-flight result.
REQ-025 After reset release, the first capture SHALL occur on the first rising clk with rst=0 and in_valid=1.
REQ-026 A rising clk coincident with rst=1 SHALL be ignored.

Verification
REQ-027 Exhaustive: all 256 {x3..x0, y3..y0} combinations with in_valid=1, one per clock -> each result equals the bitwise AND one clock later; e.g. x=1011, y=0110 -> o=0010, pop_cnt=1, all_zero=0, all_ones=0.
REQ-028 Flags: x=1111, y=1111 -> o=1111, all_ones=1, pop_cnt=4; x=1010, y=0101 -> o=0000, all_zero=1, pop_cnt=0.
REQ-029 Hold: capture x=1100, y=1110 (o=1100), then change operands with in_valid=0 for 3 clocks -> o stays 1100 and out_valid=0.
REQ-030 Reset mid-stream: after o=1111, assert rst between clock edges -> o=0000, out_valid=0, all_zero=1 immediately, before the next edge.
REQ-031 Post-reset: release rst with in_valid=1, x=0111, y=0101 -> o=0101, out_valid=1 after the first edge.
